mmio_input_port: RTL and testbench

Memory-mapped input peripheral that the MIPS core reads over the same data bus it uses for LED, seven-segment and ADC access. It synchronizes and debounces 16 slide switches and 5 push-buttons and captures button press events in sticky flags. The core reads these over `readdata` and clears them with `memwrite` stores. An optional interrupt output is available. It sits beside the existing output peripherals in the memory map and returns zero for any address outside its window.

---
 rtl/mmio_input_port.sv | 176 +++++++++++++++++
 tb/tb_mmio_input_port.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_input_port.sv
// mmio_input_port: memory-mapped switch/button input peripheral for the MIPS
// data bus. Raw inputs are synchronized with two flops and then debounced.
// Rising edges of the debounced buttons are latched in write-1-to-clear
// sticky flags.
// The optional level interrupt is enabled with the macro MMIO_IN_IRQ_EN.
// Register window (offset = dataadr[3:2]):
//   0x0 SW_STATE, 0x4 BTN_STATE, 0x8 BTN_EDGE (W1C), 0xC CTRL.
module mmio_input_port #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0080,
    parameter int          DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] sw,
    input  logic [4:0]  btn
`ifdef MMIO_IN_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int NB    = 21;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    w_raw;
    logic [NB-1:0]    r_sync1;
    logic [NB-1:0]    r_sync2;
    logic [NB-1:0]    r_stable;
    logic [CNT_W-1:0] r_cnt [NB];
    logic [NB-1:0]    w_flip;
    logic [4:0]       w_btn_rise;
    logic [4:0]       r_edge;
    logic [4:0]       r_mask;
    logic [4:0]       w_edge_clr;
    logic             w_irq_en;
    logic             w_sel;
    logic [1:0]       w_off;
    logic             w_wr;
    logic             w_unused_bits;

    // Buttons occupy bits [20:16] of the per-bit vector, switches bits [15:0].
    assign w_raw   = {btn, sw};
    assign w_sel   = (dataadr[31:4] == BASE_ADDR[31:4]);
    assign w_off   = dataadr[3:2];
    assign w_wr    = memwrite & w_sel;
    assign w_unused_bits = ^{writedata[31:6], writedata[0], dataadr[1:0], BASE_ADDR[3:0]};

    // Two-flop synchronizer for every asynchronous input bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A bit flips once it has disagreed with the stable value for the full count.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < NB; i++) begin
            if ((r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX)) begin
                w_flip[i] = 1'b1;
            end else begin
                w_flip[i] = 1'b0;
            end
        end
    end

    // Debounced rise of a button is a flip while its stable value is still 0.
    assign w_btn_rise = w_flip[20:16] & ~r_stable[20:16];

    // Per-bit debounce counters and stable values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stable <= '0;
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_stable[i] <= ~r_stable[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Write-1-to-clear decode for the sticky edge flags.
    always_comb begin
        w_edge_clr = 5'd0;
        if (w_wr && (w_off == 2'd2)) begin
            w_edge_clr = writedata[4:0];
        end else begin
            w_edge_clr = 5'd0;
        end
    end

    // Sticky edge flags; a new set overrides a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_edge <= 5'd0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | (w_btn_rise & r_mask);
        end
    end

    // Per-button edge mask held in CTRL[5:1].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= 5'h1F;
        end else if (w_wr && (w_off == 2'd3)) begin
            r_mask <= writedata[5:1];
        end else begin
            r_mask <= r_mask;
        end
    end

`ifdef MMIO_IN_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // Interrupt enable held in CTRL[0].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_en <= 1'b0;
        end else if (w_wr && (w_off == 2'd3)) begin
            r_irq_en <= writedata[0];
        end else begin
            r_irq_en <= r_irq_en;
        end
    end

    // Registered level interrupt: enabled and any sticky flag pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en & (|r_edge);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    // Read mux; addresses outside the window return zero.
    always_comb begin
        readdata = 32'h0;
        if (w_sel) begin
            case (w_off)
                2'd0:    readdata = {16'h0, r_stable[15:0]};
                2'd1:    readdata = {27'h0, r_stable[20:16]};
                2'd2:    readdata = {27'h0, r_edge};
                2'd3:    readdata = {26'h0, r_mask, w_irq_en};
                default: readdata = 32'h0;
            endcase
        end else begin
            readdata = 32'h0;
        end
    end

endmodule

// File: tb/tb_mmio_input_port.sv
// Directed self-checking bench for mmio_input_port (DEBOUNCE_CYCLES=4,
// BASE_ADDR=0x80). Inputs change 1 time unit after a rising edge and outputs
// are sampled 2 units after it.
module tb_mmio_input_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [15:0] sw = 16'h0;
    logic [4:0]  btn = 5'h0;
`ifdef MMIO_IN_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    mmio_input_port #(
        .BASE_ADDR      (32'h0000_0080),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .readdata (readdata),
        .sw       (sw),
        .btn      (btn)
`ifdef MMIO_IN_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then step past it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        dataadr = addr;
        #1;
        check_eq(tag, readdata, exp);
    endtask

    // Store that lands on the next rising edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        tick(1);
        memwrite  = 1'b0;
        writedata = 32'h0;
    endtask

    initial begin
        // Reset state
        #2;
        rd_check("rst_sw",   32'h80, 32'h0);
        rd_check("rst_btn",  32'h84, 32'h0);
        rd_check("rst_edge", 32'h88, 32'h0);
        rd_check("rst_ctrl", 32'h8C, 32'h3E);
`ifdef MMIO_IN_IRQ_EN
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
`endif
        tick(1);
        reset = 1'b1;
        tick(2);

        // Switch debounce latency: 5 edges at 0, value on the 6th
        sw = 16'hA5A5;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            rd_check("sw_wait", 32'h80, 32'h0);
        end
        tick(1);
        rd_check("sw_6th", 32'h80, 32'h0000_A5A5);

        // 3-cycle glitch on sw[0] is rejected
        sw = 16'hA5A4;
        tick(3);
        sw = 16'hA5A5;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            rd_check("sw_glitch", 32'h80, 32'h0000_A5A5);
        end

        // Button press: state follows, edge flag sticks after release
        btn = 5'h04;
        tick(5);
        rd_check("btn_wait", 32'h84, 32'h0);
        rd_check("edge_wait", 32'h88, 32'h0);
        tick(1);
        rd_check("btn_up", 32'h84, 32'h4);
        rd_check("edge_set", 32'h88, 32'h4);
        tick(4);
        btn = 5'h00;
        tick(6);
        rd_check("btn_down", 32'h84, 32'h0);
        rd_check("edge_stick", 32'h88, 32'h4);
        wr(32'h88, 32'h4);
        rd_check("edge_clr", 32'h88, 32'h0);

        // Set and clear on the same edge: set wins
        btn = 5'h01;
        tick(5);
        wr(32'h88, 32'h1);
        rd_check("collide", 32'h88, 32'h1);
        wr(32'h88, 32'h1);
        rd_check("clr_b0", 32'h88, 32'h0);
        btn = 5'h00;
        tick(6);

        // Mask off button 0
        wr(32'h8C, 32'h3C);
        rd_check("ctrl_3c", 32'h8C, 32'h3C);
        btn = 5'h01;
        tick(6);
        rd_check("mask_btn", 32'h84, 32'h1);
        rd_check("mask_edge", 32'h88, 32'h0);
        btn = 5'h00;
        tick(6);
        wr(32'h8C, 32'h3E);

        // Read-only registers, decode, ignored low address bits
        wr(32'h80, 32'hFFFF_FFFF);
        rd_check("ro_sw", 32'h80, 32'h0000_A5A5);
        wr(32'h84, 32'hFFFF_FFFF);
        rd_check("ro_btn", 32'h84, 32'h0);
        rd_check("out_win", 32'h90, 32'h0);
        rd_check("low_bits", 32'h8F, 32'h3E);

        // CTRL bit0 writability depends on the interrupt build
        wr(32'h8C, 32'h3F);
`ifdef MMIO_IN_IRQ_EN
        rd_check("ctrl_3f", 32'h8C, 32'h3F);
        btn = 5'h02;
        tick(6);
        rd_check("irq_flag", 32'h88, 32'h2);
        check_eq("irq_lag", {31'h0, irq}, 32'h0);
        tick(1);
        check_eq("irq_on", {31'h0, irq}, 32'h1);
        wr(32'h88, 32'h2);
        check_eq("irq_hold", {31'h0, irq}, 32'h1);
        tick(1);
        check_eq("irq_off", {31'h0, irq}, 32'h0);
        btn = 5'h00;
        tick(6);
        btn = 5'h02;
        tick(7);
        check_eq("irq_on2", {31'h0, irq}, 32'h1);
        reset = 1'b0;
        #1;
        check_eq("irq_rst", {31'h0, irq}, 32'h0);
        tick(1);
        reset = 1'b1;
        btn = 5'h00;
        tick(1);
`else
        rd_check("ctrl_b0", 32'h8C, 32'h3E);
`endif

        // Reset mid-count restarts debounce from scratch
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        sw = 16'h0F0F;
        tick(3);
        reset = 1'b0;
        #1;
        rd_check("mid_rst_sw", 32'h80, 32'h0);
        rd_check("mid_rst_ctrl", 32'h8C, 32'h3E);
        tick(1);
        reset = 1'b1;
        tick(5);
        rd_check("restart_wait", 32'h80, 32'h0);
        tick(1);
        rd_check("restart_val", 32'h80, 32'h0000_0F0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
